// File: rtl/sevenseg_pkg.sv
// Shared definitions for the bus-mapped seven-segment scan driver:
// register map, field positions and glyph decoding.
package sevenseg_pkg;

    localparam logic [7:0] DIG0_OFS = 8'd0;
    localparam logic [7:0] DIG1_OFS = 8'd1;
    localparam logic [7:0] DIG2_OFS = 8'd2;
    localparam logic [7:0] DIG3_OFS = 8'd3;
    localparam logic [7:0] CTRL_OFS = 8'd4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int DP_BIT     = 4;
    localparam int BLANK_BIT  = 7;
    localparam int EN_BIT     = 0;
    localparam int SEG_DP_BIT = 7;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] hex;
    } dig_reg_t;

    localparam dig_reg_t DIG_RESET = '{blank: 1'b1, dp: 1'b0, hex: 4'h0};

    // Active-low glyphs with the decimal point off; b and d are lowercase.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] seg;
        case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    function automatic logic [7:0] digit_segments(input dig_reg_t r);
        logic [7:0] seg;
        seg = hex_to_seg(r.hex);
        seg[SEG_DP_BIT] = ~r.dp;
        if (r.blank) begin
            seg = SEG_BLANK;
        end
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Digit scan timing: per-digit prescaler, digit index and the anti-ghosting
// guard window during which every anode stays off.
module sevenseg_scan_timer #(
    parameter int DIV          = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       en,
    output logic [1:0] idx,
    output logic       lit
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GRD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [GRD_W-1:0] guard_q, guard_d;
    logic             tick;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        guard_d = guard_q;
        if (!en) begin
            // Disabled: park so that re-enabling starts at digit 0 with a full guard.
            cnt_d   = '0;
            idx_d   = 2'd0;
            guard_d = GRD_W'(GUARD_CYCLES);
        end else if (tick) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            guard_d = GRD_W'(GUARD_CYCLES);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (guard_q != '0) begin
                guard_d = guard_q - GRD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            guard_q <= GRD_W'(GUARD_CYCLES);
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            guard_q <= guard_d;
        end
    end

    assign idx = idx_q;
    assign lit = en && (guard_q == '0);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver behind the 8-bit processor bus:
// write-only digit/control registers, glyph decode and registered pin outputs.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'hD0,
    parameter int         CLK_MHZ      = 100,
    parameter int         SCAN_KHZ     = 1,
    parameter int         GUARD_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BUS_WE,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    output logic [3:0] SEL,
    output logic [7:0] DIGIT
);

    localparam int DIV = CLK_MHZ * 1000 / SCAN_KHZ;

    logic [7:0] ofs;
    dig_reg_t   dig_regs [4];
    logic       en_q, en_d;
    logic [1:0] scan_idx;
    logic       scan_lit;
    logic [3:0] sel_q, sel_d;
    logic [7:0] digit_q, digit_d;
    logic [1:0] unused_bus_bits;

    assign ofs             = BUS_ADDR - BASE_ADDR;
    assign unused_bus_bits = BUS_DATA[6:5];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dig
            dig_reg_t dig_q, dig_d;

            always_comb begin
                dig_d = dig_q;
                if (BUS_WE && (ofs == DIG0_OFS + 8'(gi))) begin
                    dig_d.blank = BUS_DATA[BLANK_BIT];
                    dig_d.dp    = BUS_DATA[DP_BIT];
                    dig_d.hex   = BUS_DATA[3:0];
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    dig_q <= DIG_RESET;
                end else begin
                    dig_q <= dig_d;
                end
            end

            assign dig_regs[gi] = dig_q;
        end
    endgenerate

    always_comb begin
        en_d = en_q;
        if (BUS_WE && (ofs == CTRL_OFS)) begin
            en_d = BUS_DATA[EN_BIT];
        end
    end

    sevenseg_scan_timer #(
        .DIV          (DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk   (CLK),
        .RESET (RESET),
        .en    (en_q),
        .idx   (scan_idx),
        .lit   (scan_lit)
    );

    // Output registers see the freshly written digit one edge after the write.
    always_comb begin
        sel_d   = 4'hF;
        digit_d = SEG_BLANK;
        if (scan_lit) begin
            sel_d   = ~(4'b0001 << scan_idx);
            digit_d = digit_segments(dig_regs[scan_idx]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            en_q    <= 1'b1;
            sel_q   <= 4'hF;
            digit_q <= SEG_BLANK;
        end else begin
            en_q    <= en_d;
            sel_q   <= sel_d;
            digit_q <= digit_d;
        end
    end

    assign SEL   = sel_q;
    assign DIGIT = digit_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver: a slot-arithmetic model predicts
// SEL/DIGIT for every clock edge and a monitor compares each cycle.
module tb_sevenseg_scan_driver;

    localparam int         CLK_MHZ  = 1;
    localparam int         SCAN_KHZ = 10;
    localparam int         GUARD    = 16;
    localparam int         DIV      = CLK_MHZ * 1000 / SCAN_KHZ;
    localparam logic [7:0] BASE     = 8'hD0;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BUS_WE = 1'b0;
    logic [7:0] BUS_ADDR = 8'h00;
    logic [7:0] BUS_DATA = 8'h00;
    logic [3:0] SEL;
    logic [7:0] DIGIT;

    sevenseg_scan_driver #(
        .BASE_ADDR    (BASE),
        .CLK_MHZ      (CLK_MHZ),
        .SCAN_KHZ     (SCAN_KHZ),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUS_WE   (BUS_WE),
        .BUS_ADDR (BUS_ADDR),
        .BUS_DATA (BUS_DATA),
        .SEL      (SEL),
        .DIGIT    (DIGIT)
    );

    always #5 CLK = ~CLK;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        logic [3:0] sel;
        logic [7:0] digit;
        int         cyc;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Model state as of the most recent edge: enabled edges since scan start.
    logic [7:0] m_dig [4];
    bit         m_en   = 1'b1;
    int         m_s    = 0;
    bit         m_live = 1'b0;

    function automatic logic [7:0] m_decode(input logic [7:0] r);
        if (r[7]) return 8'hFF;
        return glyph[r[3:0]] & (r[4] ? 8'h7F : 8'hFF);
    endfunction

    // Reference model: slot = s / DIV, lit once s mod DIV reaches the guard length.
    initial begin : model
        forever begin : step
            exp_t       e;
            logic [7:0] off;
            int         slot;
            @(posedge CLK);
            cyc++;
            if (RESET) begin
                e.sel   = 4'hF;
                e.digit = 8'hFF;
                m_live  = 1'b1;
                m_s     = 0;
                m_en    = 1'b1;
                for (int i = 0; i < 4; i++) m_dig[i] = 8'h80;
            end else if (m_live) begin
                slot = (m_s / DIV) % 4;
                if (m_en && (m_s % DIV) >= GUARD) begin
                    e.sel   = ~(4'b0001 << slot);
                    e.digit = m_decode(m_dig[slot]);
                end else begin
                    e.sel   = 4'hF;
                    e.digit = 8'hFF;
                end
                m_s = m_en ? m_s + 1 : 0;
                if (BUS_WE) begin
                    off = BUS_ADDR - BASE;
                    if (off < 8'd4) m_dig[off[1:0]] = BUS_DATA;
                    else if (off == 8'd4) m_en = BUS_DATA[0];
                end
            end
            if (m_live) begin
                e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        forever begin : mon_step
            exp_t e;
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (SEL === e.sel && DIGIT === e.digit) begin
                    n_pass++;
                end else begin
                    $display("FAIL scan cyc=%0d got SEL=%h DIGIT=%h expected SEL=%h DIGIT=%h",
                             e.cyc, SEL, DIGIT, e.sel, e.digit);
                end
            end
        end
    end

    task automatic cycle(input logic we, input logic [7:0] addr, input logic [7:0] data,
                         input logic rst);
        @(negedge CLK);
        BUS_WE   = we;
        BUS_ADDR = addr;
        BUS_DATA = data;
        RESET    = rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        cycle(1'b1, addr, data, 1'b0);
    endtask

    // Advance until the next edge will see slot `slot` at phase `phase`; bounded.
    task automatic wait_phase(input int slot, input int phase, input string what);
        int budget;
        budget = 0;
        while (!(m_en && ((m_s / DIV) % 4) == slot && (m_s % DIV) == phase) && budget < 2000) begin
            idle(1);
            budget++;
        end
        if (budget >= 2000) begin
            n_checks++;
            $display("FAIL wait_%s got timeout expected slot=%0d phase=%0d", what, slot, phase);
        end
    endtask

    initial begin : stim
        logic [7:0] a;
        logic [7:0] d;
        int         r;

        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        idle(430);

        wr(BASE + 8'd0, 8'h00);
        wr(BASE + 8'd1, 8'h01);
        wr(BASE + 8'd2, 8'h0A);
        wr(BASE + 8'd3, 8'h1F);
        idle(850);

        wait_phase(0, GUARD + 10, "dig0_lit");
        wr(BASE + 8'd0, 8'h10);
        idle(5);

        // Writes coinciding with a tick: incoming digit, then outgoing digit.
        wait_phase(1, DIV - 1, "tick_in");
        wr(BASE + 8'd2, 8'h05);
        wait_phase(2, DIV - 1, "tick_out");
        wr(BASE + 8'd2, 8'h1C);
        idle(450);

        wait_phase(1, 50, "mid_slot");
        wr(BASE + 8'd4, 8'h00);
        idle(300);
        wr(BASE + 8'd4, 8'h01);
        idle(450);

        wr(BASE + 8'd5, 8'h00);
        wr(BASE - 8'd1, 8'h00);
        idle(450);

        wait_phase(2, GUARD + 20, "dig2_lit");
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        idle(450);

        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 60) begin
                a = BASE + 8'($urandom_range(0, 3));
                d = 8'($urandom);
                wr(a, d);
            end else if (r < 66) begin
                d = 8'($urandom);
                if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                wr(BASE + 8'd4, d);
            end else if (r < 80) begin
                a = 8'($urandom);
                if (8'(a - BASE) < 8'd5) a = BASE + 8'd5;
                wr(a, 8'($urandom));
            end else if (r < 82) begin
                cycle(1'b0, 8'h00, 8'h00, 1'b1);
            end else begin
                idle(1);
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Bus-mapped four-digit seven-segment display driver. It sits directly behind the shared 8-bit processor bus and replaces the separate register and state-machine path. It holds per-digit hex, decimal-point and blank registers plus a control register. It time-multiplexes the digits onto the active-low anode/segment pins using a single-clock tick enable rather than a derived clock.

## Interface
Parameters:
- BASE_ADDR, 8'hD0, first bus address of the 5-register window
- CLK_MHZ, 100, input clock frequency
- SCAN_KHZ, 1, per-digit dwell rate; DIV = CLK_MHZ*1000/SCAN_KHZ cycles per digit
- GUARD_CYCLES, 16, all-anodes-off cycles after each digit change (anti-ghosting); must be < DIV

Ports:
- CLK  in  1  system clock; one clock for the whole block
- RESET  in  1  reset, synchronous, active-high
- BUS_WE  in  1  bus write strobe, sampled on CLK rising edge
- BUS_ADDR  in  8  bus address
- BUS_DATA  in  8  bus write data
- SEL  out  4  anode select, active-low one-hot; SEL[0] = rightmost digit
- DIGIT  out  8  segments, active-low; bit 7 = dp, bits 6:0 = g..a

## Operation
- Register map (write-only):
  - BASE+0..BASE+3 are DIGn: [3:0] hex value, [4] dp on, [7] blank, [6:5] ignored.
  - BASE+4 is CTRL: [0] enable; other bits ignored.
  - Other addresses are ignored.
- Reset values: DIG0..3 = 8'h80 (blank); CTRL = 8'h01; SEL = 4'hF; DIGIT = 8'hFF; idx = 0; prescaler = 0; guard counter = GUARD_CYCLES.
- Prescaler counts 0..DIV-1 and wraps. A tick is asserted when the count is DIV-1.
- On each tick, idx advances 0→1→2→3→0 and the guard counter reloads to GUARD_CYCLES.
- Guard counter decrements to 0. While it is nonzero, SEL = 4'hF and DIGIT = 8'hFF.
- When guard = 0 and enabled:
  - SEL = ~(1<<idx).
  - DIGIT = decode(DIG[idx]). A blank register gives 8'hFF. Otherwise segments come from standard hex glyphs (b, d lowercase), with dp bit 0 when dp is on.
- Hex glyphs, active-low, dp off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- CTRL.enable = 0:
  - Prescaler and idx are held at 0 and the guard counter is held at GUARD_CYCLES.
  - SEL = 4'hF, DIGIT = 8'hFF.
  - Register writes are still accepted.
  - Re-enabling starts from digit 0 with a full guard period.

## Timing
- SEL and DIGIT are registered outputs; no combinational path runs from any input to any output.
- Write latency:
  - A write sampled at edge N updates the register at edge N.
  - If the digit is active and the guard has expired, DIGIT reflects the new value after edge N+1.
- A CTRL write clearing enable at edge N gives SEL = 4'hF after edge N+1.
- After RESET deasserts, the first anode (SEL = 4'hE) asserts GUARD_CYCLES+1 cycles later.
- Each digit is lit for DIV-GUARD_CYCLES cycles per DIV-cycle slot, so the full frame is 4*DIV cycles.
- Simultaneous tick and write to the outgoing or incoming digit: the write is applied normally, and the incoming digit shows the new value once its guard expires.
- RESET mid-scan: all state returns to reset values at that edge, with outputs off on the next cycle.
- idx wraps from 3 to 0 with no extra dead cycle beyond the guard.

## Structure
- Shared package sevenseg_pkg holds:
  - register offsets (DIG0_OFS..DIG3_OFS, CTRL_OFS)
  - the SEG_BLANK = 8'hFF constant
  - bit positions for dp and blank
  - the hex-to-segment function
- One sub-module, sevenseg_scan_timer, contains the prescaler, idx, and guard counter. It has inputs en and RESET and outputs idx[1:0] and lit.
- The top level holds the register file, decode and output registers.

## Test plan
- Reset, then run with DIV=100 and GUARD=16 → SEL=F and DIGIT=FF for 17 cycles, then SEL=E and DIGIT=FF (DIG0 blank).
- Write D0=00, D1=01, D2=0A, D3=1F → per slot: SEL E/DIGIT C0, SEL D/F9, SEL B/88, SEL 7/0E; the 4-slot sequence repeats every 400 cycles.
- Write D0=10 while digit 0 is lit → DIGIT changes C0→40 exactly two edges after the write strobe.
- Write CTRL=00 mid-slot → SEL=F and DIGIT=FF next cycle with no further scanning. Then write CTRL=01 → digit 0 is lit after 17 cycles.
- Writes to BASE+5 and BASE-1 with data 00 → no register or output change.
- Assert RESET during digit 2's lit window → outputs F/FF the next cycle and all registers return to reset values.
